// File: rtl/dff_arb_pkg.sv
// Shared types and defaults for the dff_reg_arbiter slice.
// Optional hold-grant feature is built only with DFF_ARB_LOCK_EN.
package dff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  // Bits needed to index n requesters.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dff_reg.sv
// WIDTH-bit DFF register with load enable and synchronous active-low reset.
module dff_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (load) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter and write sequencer owning the write path of a shared register.
// Define DFF_ARB_LOCK_EN to add the lock port for back-to-back writes by one requester.
//
// state | meaning
// IDLE  | no grant; pick next requester starting from ptr
// GRANT | gnt[win] high; write q if req[win] still high, else abort
// ACK   | gnt[win] and ack[win] high; advance ptr (or re-grant under lock)
module dff_reg_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef DFF_ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);

  localparam int PW = clog2(NREQ);

  state_t          state_d, state_q;
  logic [PW-1:0]   win_d, win_q;
  logic [PW-1:0]   ptr_d, ptr_q;
  logic [NREQ-1:0] gnt_d, gnt_q;
  logic [NREQ-1:0] ack_d, ack_q;
  logic            busy_d, busy_q;
  logic            load;
  logic            found;
  int              idx;
  logic [PW-1:0]   ptr_next;

  assign ptr_next = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
    found   = 1'b0;
    idx     = 0;
    gnt_d   = '0;
    ack_d   = '0;

    case (state_q)
      IDLE: begin
        for (int i = 0; i < NREQ; i++) begin
          idx = int'(ptr_q) + i;
          if (idx >= NREQ) idx = idx - NREQ;
          if (!found && req[idx]) begin
            found = 1'b1;
            win_d = PW'(idx);
          end
        end
        if (found) state_d = GRANT;
      end
      GRANT: begin
        if (req[win_q]) begin
          load    = 1'b1;
          state_d = ACK;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
`ifdef DFF_ARB_LOCK_EN
        if (lock[win_q] && req[win_q]) begin
          state_d = GRANT;
        end else begin
          ptr_d   = ptr_next;
          state_d = IDLE;
        end
`else
        ptr_d   = ptr_next;
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered: decode them from the next state.
    if (state_d != IDLE) gnt_d[win_d] = 1'b1;
    if (state_d == ACK)  ack_d[win_d] = 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  dff_reg #(.WIDTH(WIDTH)) u_dff_reg (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .d     (wdata[win_q*WIDTH +: WIDTH]),
    .q     (q)
  );

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Directed self-checking bench for dff_reg_arbiter (NREQ=4, WIDTH=8).
module tb_dff_reg_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
`ifdef DFF_ARB_LOCK_EN
  logic [3:0]  lock;
`endif
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  dff_reg_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wdata (wdata),
`ifdef DFF_ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .ack   (ack),
    .q     (q),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_gnt"},  32'(gnt),  32'h0);
    check_val({tag, "_ack"},  32'(ack),  32'h0);
    check_val({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  logic [7:0] fair_data [4];

  initial begin
    reset = 1'b0;
    req   = '0;
    wdata = '0;
`ifdef DFF_ARB_LOCK_EN
    lock  = '0;
`endif
    step();

    // Reset held with all requests pending.
    req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step();
      check_idle("rst");
      check_val("rst_q", 32'(q), 32'h00);
    end
    req   = '0;
    reset = 1'b1;
    step();

    // Single write from requester 2.
    wdata[23:16] = 8'hA5;
    req = 4'b0100;
    step();
    check_val("single_gnt",  32'(gnt),  32'h4);
    check_val("single_ack0", 32'(ack),  32'h0);
    check_val("single_busy", 32'(busy), 32'h1);
    step();
    check_val("single_ack", 32'(ack), 32'h4);
    check_val("single_q",   32'(q),   32'hA5);
    req = '0;
    step();
    check_idle("single_done");

    // Reset pulse so the pointer starts at 0 for the fairness run.
    reset = 1'b0;
    step();
    reset = 1'b1;

    fair_data[0] = 8'h11;
    fair_data[1] = 8'h22;
    fair_data[2] = 8'h33;
    fair_data[3] = 8'h44;
    wdata = {fair_data[3], fair_data[2], fair_data[1], fair_data[0]};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check_val($sformatf("fair%0d_gnt", k), 32'(gnt), 32'(1 << (k % 4)));
      check_val($sformatf("fair%0d_ack0", k), 32'(ack), 32'h0);
      step();
      check_val($sformatf("fair%0d_ack", k), 32'(ack), 32'(1 << (k % 4)));
      check_val($sformatf("fair%0d_q", k), 32'(q), 32'(fair_data[k % 4]));
      step();
      check_idle($sformatf("fair%0d_idle", k));
    end
    req = '0;
    step();

    // Withdraw during GRANT: pointer sits at 1 and must stay there.
    req = 4'b0010;
    step();
    check_val("wd_gnt", 32'(gnt), 32'h2);
    req = '0;
    step();
    check_idle("wd_abort");
    check_val("wd_q", 32'(q), 32'h11);
    req = 4'b1010;
    step();
    check_val("wd_regnt", 32'(gnt), 32'h2);
    step();
    check_val("wd_ack", 32'(ack), 32'h2);
    check_val("wd_q2",  32'(q),   32'h22);
    req = '0;
    step();

    // Reset during ACK of requester 2 (pointer was 2 beforehand).
    wdata[23:16] = 8'h3C;
    req = 4'b0100;
    step();
    check_val("mid_gnt", 32'(gnt), 32'h4);
    step();
    check_val("mid_ack", 32'(ack), 32'h4);
    check_val("mid_q",   32'(q),   32'h3C);
    reset = 1'b0;
    req   = '0;
    step();
    check_idle("mid_rst");
    check_val("mid_rst_q", 32'(q), 32'h00);
    reset = 1'b1;
    req   = 4'b0110;
    step();
    check_val("mid_ptr0_gnt", 32'(gnt), 32'h2);
    step();
    check_val("mid_ptr0_ack", 32'(ack), 32'h2);
    check_val("mid_ptr0_q",   32'(q),   32'h22);
    req = '0;
    step();

`ifdef DFF_ARB_LOCK_EN
    // Pointer is 2: requester 3 wins and holds the grant under lock.
    wdata[31:24] = 8'hD3;
    wdata[7:0]   = 8'hD0;
    req  = 4'b1001;
    lock = 4'b1000;
    step();
    check_val("lock_gnt0", 32'(gnt), 32'h8);
    for (int w = 0; w < 3; w++) begin
      if (w > 0) begin
        step();
        check_val($sformatf("lock%0d_gnt", w), 32'(gnt), 32'h8);
        check_val($sformatf("lock%0d_noack", w), 32'(ack), 32'h0);
      end
      step();
      check_val($sformatf("lock%0d_ack", w), 32'(ack), 32'h8);
      check_val($sformatf("lock%0d_q", w), 32'(q), 32'hD3);
    end
    lock = '0;
    req  = 4'b0001;
    step();
    check_idle("lock_rel");
    step();
    check_val("lock_r0_gnt", 32'(gnt), 32'h1);
    step();
    check_val("lock_r0_ack", 32'(ack), 32'h1);
    check_val("lock_r0_q",   32'(q),   32'hD0);
    req = '0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
